// File: rtl/ber_link_sequencer_if.sv
// Host/datapath bundle for the BER sequencer: run control, recovered bit stream, status and counts.
// No flow control: one optional bit per cycle qualified by rx_bit_valid; status is level, done is a pulse.
interface ber_link_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             rx_bit;
  logic             rx_bit_valid;
  logic             tx_en;
  logic             rx_en;
  logic             busy;
  logic             locked;
  logic             done;
  logic             sync_fail;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start, abort, rx_bit, rx_bit_valid,
    input  tx_en, rx_en, busy, locked, done, sync_fail, bit_count, err_count
  );

  modport slave (
    input  start, abort, rx_bit, rx_bit_valid,
    output tx_en, rx_en, busy, locked, done, sync_fail, bit_count, err_count
  );
endinterface

// File: rtl/ber_link_sequencer.sv
// Runs one BER measurement: warm-up, LFSR self-sync, then error counting over a fixed window; status is registered state.
// Invalid cycles stall all shifting/counting; BER_LOSS_OF_SYNC_EN adds re-sync on a burst of consecutive errors.
module ber_link_sequencer #(
  parameter int                LFSR_W      = 7,
  parameter logic [LFSR_W-1:0] TAP_MASK    = 7'b1100000,
  parameter int                WARMUP_CYC  = 64,
  parameter int                LOCK_BITS   = 32,
  parameter int                MAX_RETRY   = 3,
  parameter int                WINDOW_BITS = 1024,
  parameter int                CNT_W       = 16
`ifdef BER_LOSS_OF_SYNC_EN
  , parameter int              LOS_THRESH  = 8
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  ber_link_sequencer_if.slave   bus
);

  localparam int WARM_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int SEED_W  = $clog2(LFSR_W + 1);
  localparam int LOCK_W  = (LOCK_BITS > 1) ? $clog2(LOCK_BITS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
  // A window wider than the counter ends the run when bit_count saturates.
  localparam longint WIN_END = (WINDOW_BITS > CNT_MAX) ? CNT_MAX : longint'(WINDOW_BITS);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_END - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_SEED, S_VERIFY, S_MEASURE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [LFSR_W-1:0]  lfsr;
  logic [WARM_W-1:0]  warm_cnt;
  logic [SEED_W-1:0]  seed_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [RETRY_W-1:0] retry;
  logic [CNT_W-1:0]   bit_count_q, err_count_q;
  logic               sync_fail_q;

  logic               pred, mismatch;
  logic [LFSR_W-1:0]  shift_rx, shift_pred;
  logic               fail_attempt, fail_final, los_trip;

`ifdef BER_LOSS_OF_SYNC_EN
  localparam int LOS_W = (LOS_THRESH > 1) ? $clog2(LOS_THRESH) : 1;
  logic [LOS_W-1:0]   los_cnt;
`endif

  assign pred       = ^(lfsr & TAP_MASK);
  assign mismatch   = bus.rx_bit != pred;
  assign shift_rx   = {lfsr[LFSR_W-2:0], bus.rx_bit};
  assign shift_pred = {lfsr[LFSR_W-2:0], pred};

  always_comb begin
    state_nxt    = state;
    fail_attempt = 1'b0;
    fail_final   = 1'b0;
    los_trip     = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_WARMUP;
      S_WARMUP: if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) state_nxt = S_SEED;
      S_SEED: begin
        if (bus.rx_bit_valid && seed_cnt == SEED_W'(LFSR_W - 1)) begin
          // An all-zero seed is the LFSR lock-up state and can never track the stream.
          if (|shift_rx) state_nxt = S_VERIFY;
          else           fail_attempt = 1'b1;
        end
      end
      S_VERIFY: begin
        if (bus.rx_bit_valid) begin
          if (mismatch)                               fail_attempt = 1'b1;
          else if (lock_cnt == LOCK_W'(LOCK_BITS - 1)) state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (bus.rx_bit_valid) begin
          if (bit_count_q == WIN_LAST) begin
            state_nxt = S_DONE;
          end
`ifdef BER_LOSS_OF_SYNC_EN
          else if (mismatch && los_cnt == LOS_W'(LOS_THRESH - 1)) begin
            state_nxt = S_SEED;
            los_trip  = 1'b1;
          end
`endif
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (fail_attempt) begin
      fail_final = retry >= RETRY_W'(MAX_RETRY);
      state_nxt  = fail_final ? S_DONE : S_SEED;
    end

    if (bus.abort) begin
      state_nxt    = S_IDLE;
      fail_attempt = 1'b0;
      fail_final   = 1'b0;
      los_trip     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      lfsr        <= '0;
      warm_cnt    <= '0;
      seed_cnt    <= '0;
      lock_cnt    <= '0;
      retry       <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
      sync_fail_q <= 1'b0;
`ifdef BER_LOSS_OF_SYNC_EN
      los_cnt     <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (!bus.abort) begin
        case (state)
          S_IDLE: begin
            warm_cnt <= '0;
            if (bus.start) begin
              bit_count_q <= '0;
              err_count_q <= '0;
              sync_fail_q <= 1'b0;
              retry       <= '0;
            end
          end
          S_WARMUP: begin
            warm_cnt <= warm_cnt + WARM_W'(1);
            seed_cnt <= '0;
          end
          S_SEED: begin
            if (bus.rx_bit_valid) begin
              lfsr     <= shift_rx;
              seed_cnt <= seed_cnt + SEED_W'(1);
              lock_cnt <= '0;
            end
          end
          S_VERIFY: begin
            if (bus.rx_bit_valid) begin
              lfsr     <= shift_pred;
              lock_cnt <= lock_cnt + LOCK_W'(1);
`ifdef BER_LOSS_OF_SYNC_EN
              los_cnt  <= '0;
`endif
            end
          end
          S_MEASURE: begin
            if (bus.rx_bit_valid) begin
              lfsr        <= shift_pred;
              bit_count_q <= bit_count_q + CNT_W'(1);
              if (mismatch && err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
`ifdef BER_LOSS_OF_SYNC_EN
              los_cnt     <= mismatch ? los_cnt + LOS_W'(1) : '0;
`endif
            end
          end
          default: ;
        endcase

        if (fail_attempt) begin
          seed_cnt <= '0;
          if (fail_final) sync_fail_q <= 1'b1;
          else            retry       <= retry + RETRY_W'(1);
        end
        if (los_trip) begin
          seed_cnt <= '0;
          retry    <= '0;
        end
      end
    end
  end

  assign bus.tx_en     = (state == S_WARMUP) || (state == S_SEED) ||
                         (state == S_VERIFY) || (state == S_MEASURE);
  assign bus.rx_en     = bus.tx_en;
  assign bus.busy      = state != S_IDLE;
  assign bus.locked    = state == S_MEASURE;
  assign bus.done      = state == S_DONE;
  assign bus.sync_fail = sync_fail_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ber_link_sequencer.sv
// Scoreboarded bench for ber_link_sequencer: drives an x^7+x^6+1 stream and checks run results, timing and control edges.
module tb_ber_link_sequencer;
  localparam int LFSR_W      = 7;
  localparam int WARMUP_CYC  = 64;
  localparam int LOCK_BITS   = 32;
  localparam int MAX_RETRY   = 3;
  localparam int WINDOW_BITS = 1024;
  localparam int CNT_W       = 16;

  localparam int CLEAN_LOCK_AT = WARMUP_CYC + LFSR_W + LOCK_BITS;
  localparam int CLEAN_DONE_AT = CLEAN_LOCK_AT + WINDOW_BITS;
  localparam int ZERO_DONE_AT  = WARMUP_CYC + (MAX_RETRY + 1) * LFSR_W;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  ber_link_sequencer_if #(.CNT_W(CNT_W)) bus();

  ber_link_sequencer #(
    .LFSR_W      (LFSR_W),
    .TAP_MASK    (7'b1100000),
    .WARMUP_CYC  (WARMUP_CYC),
    .LOCK_BITS   (LOCK_BITS),
    .MAX_RETRY   (MAX_RETRY),
    .WINDOW_BITS (WINDOW_BITS),
    .CNT_W       (CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int bits;
    int errs;
    int fail;
  } exp_t;
  exp_t sb[$];

  // Transmitter model: b[n] = b[n-7] ^ b[n-6], newest bit in gen[0].
  logic [6:0] gen = 7'h5A;
  task automatic next_bit(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // mode: 0 clean, 1 isolated errors + start while busy, 2 abort, 3 reset, 4 error burst
  task automatic do_run(input string name, input int vmod, input bit zeros, input int mode,
                        input int exp_bits, input int exp_errs, input int exp_fail,
                        input int exp_lock_at, input int exp_done_at, input int exp_rises);
    int   meas      = 0;
    int   lock_at   = -1;
    int   done_at   = -1;
    int   rises     = 0;
    bit   prev_lock = 1'b0;
    bit   seen_done = 1'b0;
    bit   triggered = 1'b0;
    bit   quiet_bad = 1'b0;
    logic b;
    exp_t e;

    if (mode != 2 && mode != 3) sb.push_back('{exp_bits, exp_errs, exp_fail});
    bus.start        = 1'b1;
    bus.rx_bit_valid = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.rx_bit_valid = 1'b0;
      if (bus.locked && !prev_lock) begin
        rises++;
        if (lock_at < 0) lock_at = i;
      end
      prev_lock = bus.locked;

      if (bus.done) begin
        seen_done = 1'b1;
        done_at   = i;
        e = sb.pop_front();
        check({name, "_bits"}, 32'(bus.bit_count), e.bits);
        check({name, "_errs"}, 32'(bus.err_count), e.errs);
        check({name, "_sync_fail"}, 32'(bus.sync_fail), e.fail);
        break;
      end

      if (mode == 2 && bus.locked && meas == 200) begin
        triggered        = 1'b1;
        bus.abort        = 1'b1;
        bus.rx_bit_valid = 1'b1;
        next_bit(b);
        bus.rx_bit = b;
        tick();
        bus.abort        = 1'b0;
        bus.rx_bit_valid = 1'b0;
        check("abort_ctl", 32'({bus.tx_en, bus.rx_en, bus.busy, bus.locked, bus.done}), 0);
        check("abort_bits", 32'(bus.bit_count), 200);
        check("abort_errs", 32'(bus.err_count), 0);
        repeat (4) begin
          tick();
          if (bus.done || bus.busy) quiet_bad = 1'b1;
        end
        check("abort_no_done", 32'(quiet_bad), 0);
        check("abort_bits_held", 32'(bus.bit_count), 200);
        break;
      end

      if (mode == 3 && bus.locked && meas == 300) begin
        triggered        = 1'b1;
        sys_rst_n        = 1'b0;
        bus.rx_bit_valid = 1'b1;
        next_bit(b);
        bus.rx_bit = b;
        tick();
        bus.rx_bit_valid = 1'b0;
        check("rst_ctl", 32'({bus.tx_en, bus.rx_en, bus.busy, bus.locked, bus.done, bus.sync_fail}), 0);
        check("rst_bits", 32'(bus.bit_count), 0);
        check("rst_errs", 32'(bus.err_count), 0);
        sys_rst_n = 1'b1;
        repeat (3) begin
          tick();
          if (bus.busy) quiet_bad = 1'b1;
        end
        check("rst_stays_idle", 32'(quiet_bad), 0);
        break;
      end

      if (mode == 1 && (i == 10 || (bus.locked && meas == 50))) bus.start = 1'b1;

      if ((i % vmod) == 0) begin
        bus.rx_bit_valid = 1'b1;
        if (zeros) b = 1'b0;
        else       next_bit(b);
        if (bus.locked) begin
          if (mode == 1 && (meas % 200) == 100)    b = ~b;
          if (mode == 4 && meas >= 500 && meas < 508) b = ~b;
          meas++;
        end
        bus.rx_bit = b;
      end else begin
        bus.rx_bit = 1'($urandom);
      end
    end

    bus.rx_bit_valid = 1'b0;
    if (mode == 2 || mode == 3) begin
      check({name, "_trigger_reached"}, 32'(triggered), 1);
    end else begin
      check({name, "_done_seen"}, 32'(seen_done), 1);
      if (!seen_done && sb.size() > 0) e = sb.pop_front();
      if (exp_lock_at >= 0) check({name, "_lock_cycle"}, lock_at, exp_lock_at);
      if (exp_done_at >= 0) check({name, "_done_cycle"}, done_at, exp_done_at);
      check({name, "_lock_rises"}, rises, exp_rises);
      tick();
      check({name, "_done_one_cycle"}, 32'({bus.done, bus.busy, bus.tx_en, bus.locked}), 0);
      check({name, "_bits_held"}, 32'(bus.bit_count), exp_bits);
      check({name, "_fail_held"}, 32'(bus.sync_fail), exp_fail);
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.rx_bit       = 1'b0;
    bus.rx_bit_valid = 1'b0;
    repeat (3) tick();
    check("reset_ctl", 32'({bus.tx_en, bus.rx_en, bus.busy, bus.locked, bus.done, bus.sync_fail}), 0);
    check("reset_bits", 32'(bus.bit_count), 0);
    check("reset_errs", 32'(bus.err_count), 0);
    sys_rst_n = 1'b1;
    tick();

    do_run("clean",   1, 1'b0, 0, WINDOW_BITS, 0, 0, CLEAN_LOCK_AT, CLEAN_DONE_AT, 1);
    do_run("garbage", 1, 1'b1, 0, 0,           0, 1, -1,            ZERO_DONE_AT,  0);
    do_run("errors",  1, 1'b0, 1, WINDOW_BITS, 5, 0, CLEAN_LOCK_AT, CLEAN_DONE_AT, 1);
    do_run("sparse",  3, 1'b0, 0, WINDOW_BITS, 0, 0, -1,            -1,            1);
    do_run("abort",   1, 1'b0, 2, 0,           0, 0, -1,            -1,            0);
    do_run("reset",   1, 1'b0, 3, 0,           0, 0, -1,            -1,            0);
`ifdef BER_LOSS_OF_SYNC_EN
    do_run("los",     1, 1'b0, 4, WINDOW_BITS, 8, 0, CLEAN_LOCK_AT, -1,            2);
`endif

    // start and abort together in IDLE leave the block idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", 32'({bus.busy, bus.tx_en}), 0);
    tick();
    check("start_abort_still_idle", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ber_link_sequencer.md
Name: ber_link_sequencer

Overview:
- Sequences one bit-error-rate measurement run over the M-sequence transmitter, channel and receiver chain.
- Enables the TX/RX datapath and lets the pipeline fill.
- Self-synchronises a local copy of the M-sequence LFSR to the recovered bit stream, then counts received bits and bit errors over a fixed window.
- Sits beside the system top. Reports lock, counts and completion to the test host.

Parameters:
- LFSR_W, 7, width of local LFSR; must match the transmitter M-sequence register width.
- TAP_MASK, 7'b1100000, feedback taps; bit i set means state[i] enters the XOR (default x^7+x^6+1).
- WARMUP_CYC, 64, sys_clk cycles with datapath enabled before seeding starts.
- LOCK_BITS, 32, consecutive correct predictions required to declare lock.
- MAX_RETRY, 3, failed lock attempts tolerated before giving up.
- WINDOW_BITS, 1024, valid bits counted in the measurement window.
- CNT_W, 16, width of bit and error counters.
- LOS_THRESH, 8, consecutive errors that trigger loss of sync (optional feature only).

Ports:
- sys_clk, in, 1, single block clock.
- sys_rst_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle request to begin a run; ignored unless IDLE.
- abort, in, 1, force return to IDLE from any state.
- rx_bit, in, 1, recovered data bit from receiver.
- rx_bit_valid, in, 1, rx_bit is valid this cycle; at most one bit per cycle.
- tx_en, out, 1, transmitter/M-sequence enable.
- rx_en, out, 1, receiver enable.
- busy, out, 1, high in any state other than IDLE.
- locked, out, 1, local LFSR aligned to stream.
- done, out, 1, one-cycle pulse at end of run.
- sync_fail, out, 1, run ended without lock; held until next start.
- bit_count, out, CNT_W, valid bits compared in MEASURE.
- err_count, out, CNT_W, mismatches in MEASURE; saturates at all-ones.

Behaviour:
- Reset: state=IDLE; all outputs 0; local LFSR, retry, warmup and lock counters 0.
- Clock/reset: one clock (sys_clk); reset is synchronous and active-low (sys_rst_n).
- Prediction: pred = XOR over i of (lfsr[i] & TAP_MASK[i]). Shift is lfsr <= {lfsr[LFSR_W-2:0], in_bit}.
- IDLE: tx_en=rx_en=0.
  - start: clear bit_count, err_count, sync_fail and retry count; go to WARMUP next cycle.
- WARMUP: tx_en=rx_en=1 (held high through MEASURE). Count WARMUP_CYC cycles, then go to SEED.
- SEED: each rx_bit_valid shifts rx_bit into the LFSR. After LFSR_W valid bits:
  - LFSR nonzero: go to VERIFY.
  - LFSR all-zero: treat as a failed attempt (same as a VERIFY mismatch).
- VERIFY: each valid bit compares rx_bit with pred and shifts pred (not rx_bit) into the LFSR.
  - Mismatch: retry+1. If retry exceeds MAX_RETRY, set sync_fail and go to DONE; otherwise go to SEED with the seed counter cleared.
  - LOCK_BITS consecutive matches: locked=1, go to MEASURE.
- MEASURE: each valid bit shifts pred into the LFSR, bit_count+1, and err_count+1 if rx_bit != pred (saturating).
  - The cycle bit_count reaches WINDOW_BITS, go to DONE. That final bit is counted.
  - If WINDOW_BITS exceeds the CNT_W range, bit_count saturates and the run ends at saturation.
- DONE: done=1 for exactly one cycle; tx_en=rx_en=0; locked cleared; go to IDLE. bit_count, err_count and sync_fail are held until the next start.
- Invalid cycles (rx_bit_valid=0): no LFSR shift and no counting in any state.
- abort: wins over all other events in the same cycle. Go to IDLE next cycle with tx_en=rx_en=locked=0, no done pulse, counts held.
- start while busy: ignored.
- start and abort in the same IDLE cycle: stay in IDLE.
- sys_rst_n low mid-run: immediate return to the reset state at that clock edge.

Optional Feature:
- Macro BER_LOSS_OF_SYNC_EN.
- Defined: MEASURE keeps a consecutive-error counter, cleared on any match. On reaching LOS_THRESH:
  - locked=0, go to SEED, retry cleared.
  - bit_count and err_count held, not cleared.
  - After re-lock, MEASURE resumes counting toward WINDOW_BITS.
  - Re-lock failure ends the run with sync_fail=1 and the counts preserved.
- Undefined: no consecutive-error tracking; MEASURE runs the full window regardless of error pattern.

Test Plan:
1. Clean path: start, rx_bit = true x^7+x^6+1 sequence with valid every cycle. Expect locked after WARMUP_CYC+7+32 valid bits; done after 1024 more; bit_count=1024, err_count=0, sync_fail=0.
2. Injected errors: same as 1 but flip 5 isolated bits in MEASURE. Expect err_count=5, bit_count=1024.
3. Garbage input: rx_bit constant 0. Expect the all-zero seed to fail 4 times (initial + 3 retries); done pulse, sync_fail=1, locked never 1, bit_count=0.
4. Sparse valid: rx_bit_valid high every 3rd cycle on a clean stream. Expect the same counts as 1 and no shifts on invalid cycles.
5. Control edges:
   - abort mid-MEASURE: expect IDLE next cycle, no done, tx_en=0, counts held.
   - start during busy: ignored.
   - sys_rst_n low mid-run: all outputs 0 after one clock.
6. With BER_LOSS_OF_SYNC_EN: at bit 500 of MEASURE, insert a burst of 8 errors. Expect locked drops and re-lock occurs; err_count=8, and the run ends at bit_count=1024.
